// File: rtl/bcd_lcd_writer.sv
// bcd_lcd_writer: writes three BCD digits as ASCII (optional leading-zero blanking)
// to a fixed DDRAM position of an HD44780 LCD in 8-bit write-only mode.
module bcd_lcd_writer #(
    parameter int         SETUP_CYCLES  = 4,
    parameter int         E_CYCLES      = 25,
    parameter int         WAIT_CYCLES   = 2500,
    parameter logic [6:0] POS           = 7'h00,
    parameter bit         BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd_2,
    input  logic [3:0] bcd_1,
    input  logic [3:0] bcd_0,
    input  logic       update,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [15:0] LD_SETUP = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] LD_E     = 16'(E_CYCLES - 1);
    localparam logic [15:0] LD_WAIT  = 16'(WAIT_CYCLES - 1);
    localparam logic [7:0]  CMD      = {1'b1, POS};

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  idx, idx_n;
    logic [3:0]  d2, d1, d0, d2_n, d1_n, d0_n;
    logic        busy_n, done_n, rs_n, e_n;
    logic [7:0]  data_n, ch_h, ch_t, ch_u, ch_next;
    logic        blank_h, blank_t;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return d > 4'd9 ? 8'h3F : 8'h30 + {4'h0, d};
    endfunction

    // invalid digits are never zero, so they can never be blanked
    assign blank_h = BLANK_LEADING && d2 == 4'd0;
    assign blank_t = blank_h && d1 == 4'd0;
    assign ch_h    = blank_h ? 8'h20 : asc(d2);
    assign ch_t    = blank_t ? 8'h20 : asc(d1);
    assign ch_u    = asc(d0);
    assign ch_next = idx == 2'd0 ? ch_h : idx == 2'd1 ? ch_t : ch_u;
    assign lcd_rw  = 1'b0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt == 16'd0 ? cnt : cnt - 16'd1;
        idx_n   = idx;
        d2_n    = d2;
        d1_n    = d1;
        d0_n    = d0;
        rs_n    = lcd_rs;
        data_n  = lcd_data;
        done_n  = 1'b0;
        case (state)
            IDLE: if (update) begin
                state_n = SETUP;
                cnt_n   = LD_SETUP;
                idx_n   = 2'd0;
                {d2_n, d1_n, d0_n} = {bcd_2, bcd_1, bcd_0};
                rs_n    = 1'b0;
                data_n  = CMD;
            end
            SETUP: if (cnt == 16'd0) begin
                state_n = PULSE;
                cnt_n   = LD_E;
            end
            PULSE: if (cnt == 16'd0) begin
                state_n = HOLD;
                cnt_n   = LD_WAIT;
            end
            HOLD: if (cnt == 16'd0) begin
                if (idx == 2'd3) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = SETUP;
                    cnt_n   = LD_SETUP;
                    idx_n   = idx + 2'd1;
                    rs_n    = 1'b1;
                    data_n  = ch_next;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
        e_n    = state_n == PULSE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            idx      <= 2'd0;
            {d2, d1, d0} <= 12'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            {d2, d1, d0} <= {d2_n, d1_n, d0_n};
            busy     <= busy_n;
            done     <= done_n;
            lcd_e    <= e_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
        end
    end
endmodule

// File: tb/tb_bcd_lcd_writer.sv
// tb_bcd_lcd_writer: directed bench; instance a blanks leading zeros, instance b does not.
module tb_bcd_lcd_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] bcd_2 = 4'd0, bcd_1 = 4'd0, bcd_0 = 4'd0;
    logic       update = 1'b0;
    logic       a_busy, a_done, a_rs, a_rw, a_e;
    logic [7:0] a_data;
    logic       b_busy, b_done, b_rs, b_rw, b_e;
    logic [7:0] b_data;
    logic       use_b = 1'b0;
    logic       m_busy, m_done, m_rs, m_rw, m_e;
    logic [7:0] m_data;

    int tests = 0, fails = 0;
    logic [7:0] cap_data[4];
    logic       cap_rs[4];
    int         cap_elen[4];
    int         cap_n, cap_busy, cap_done;
    logic       f_busy, f_rs;
    logic [7:0] f_data;

    bcd_lcd_writer #(.SETUP_CYCLES(2), .E_CYCLES(3), .WAIT_CYCLES(5), .POS(7'h40), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bcd_2(bcd_2), .bcd_1(bcd_1), .bcd_0(bcd_0), .update(update),
        .busy(a_busy), .done(a_done), .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_e(a_e), .lcd_data(a_data));

    bcd_lcd_writer #(.SETUP_CYCLES(2), .E_CYCLES(3), .WAIT_CYCLES(5), .POS(7'h40), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bcd_2(bcd_2), .bcd_1(bcd_1), .bcd_0(bcd_0), .update(update),
        .busy(b_busy), .done(b_done), .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_e(b_e), .lcd_data(b_data));

    always #5 clk = ~clk;

    always_comb begin
        m_busy = use_b ? b_busy : a_busy;
        m_done = use_b ? b_done : a_done;
        m_rs   = use_b ? b_rs   : a_rs;
        m_rw   = use_b ? b_rw   : a_rw;
        m_e    = use_b ? b_e    : a_e;
        m_data = use_b ? b_data : a_data;
    end

    // runs one transaction and records the bytes seen at each E rise
    task automatic capture(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u, input bit mid_change);
        logic pe;
        {bcd_2, bcd_1, bcd_0} = {h, t, u};
        cap_n = 0; cap_busy = 0; cap_done = 0; pe = 1'b0;
        for (int k = 0; k < 4; k++) begin cap_elen[k] = 0; cap_rs[k] = 1'bx; cap_data[k] = 8'hxx; end
        @(negedge clk);
        update = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin update = 1'b0; f_busy = m_busy; f_rs = m_rs; f_data = m_data; end
            if (mid_change && i == 5) {bcd_2, bcd_1, bcd_0} = {4'd9, 4'd9, 4'd9};
            if (m_busy) cap_busy++;
            if (m_done) cap_done++;
            if (m_e && !pe && cap_n < 4) begin cap_rs[cap_n] = m_rs; cap_data[cap_n] = m_data; cap_n++; end
            if (m_e && cap_n > 0) cap_elen[cap_n-1]++;
            pe = m_e;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({a_busy, a_done, a_e, a_rs, a_rw, a_data} !== 12'h000) begin
            fails++;
            $display("FAIL reset_values got busy=%b done=%b e=%b rs=%b rw=%b data=%h exp all 0", a_busy, a_done, a_e, a_rs, a_rw, a_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy got %b exp 0", a_busy); end
    endtask

    task automatic test_full;
        logic [7:0] ed[4] = '{8'hC0, 8'h32, 8'h35, 8'h35};
        logic       er[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        use_b = 1'b0;
        capture(4'd2, 4'd5, 4'd5, 1'b0);
        tests++;
        if ({f_busy, f_rs, f_data} !== {1'b1, 1'b0, 8'hC0}) begin
            fails++; $display("FAIL first_cycle got busy=%b rs=%b data=%h exp 1 0 c0", f_busy, f_rs, f_data);
        end
        tests++;
        if (cap_n !== 4) begin fails++; $display("FAIL full_bytes got %0d exp 4", cap_n); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({cap_rs[k], cap_data[k]} !== {er[k], ed[k]}) begin
                fails++; $display("FAIL full_byte%0d got rs=%b data=%h exp rs=%b data=%h", k, cap_rs[k], cap_data[k], er[k], ed[k]);
            end
            tests++;
            if (cap_elen[k] !== 3) begin fails++; $display("FAIL full_elen%0d got %0d exp 3", k, cap_elen[k]); end
        end
        tests++;
        if (cap_busy !== 40) begin fails++; $display("FAIL full_busy got %0d exp 40", cap_busy); end
        tests++;
        if (cap_done !== 1) begin fails++; $display("FAIL full_done got %0d exp 1", cap_done); end
    endtask

    task automatic test_blank;
        logic [3:0] dig[4][3] = '{'{4'd0, 4'd0, 4'd7}, '{4'd0, 4'd0, 4'd0}, '{4'd0, 4'd4, 4'd0}, '{4'd1, 4'd0, 4'd0}};
        logic [7:0] exp_b[4][3] = '{'{8'h20, 8'h20, 8'h37}, '{8'h20, 8'h20, 8'h30}, '{8'h20, 8'h34, 8'h30}, '{8'h31, 8'h30, 8'h30}};
        use_b = 1'b0;
        for (int v = 0; v < 4; v++) begin
            capture(dig[v][0], dig[v][1], dig[v][2], 1'b0);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (cap_data[k+1] !== exp_b[v][k]) begin
                    fails++; $display("FAIL blank_v%0d_b%0d got %h exp %h", v, k, cap_data[k+1], exp_b[v][k]);
                end
            end
        end
    endtask

    task automatic test_noblank;
        logic [7:0] ed[4] = '{8'hC0, 8'h30, 8'h30, 8'h37};
        use_b = 1'b1;
        capture(4'd0, 4'd0, 4'd7, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cap_data[k] !== ed[k]) begin fails++; $display("FAIL noblank_b%0d got %h exp %h", k, cap_data[k], ed[k]); end
        end
        use_b = 1'b0;
    endtask

    task automatic test_invalid_latch;
        logic [7:0] ed[3] = '{8'h3F, 8'h33, 8'h30};
        use_b = 1'b0;
        capture(4'd12, 4'd3, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (cap_data[k+1] !== ed[k]) begin fails++; $display("FAIL invalid_b%0d got %h exp %h", k, cap_data[k+1], ed[k]); end
        end
    endtask

    task automatic test_reset_mid_pulse;
        int nd, nb;
        bit seen;
        seen = 1'b0; nd = 0; nb = 0;
        {bcd_2, bcd_1, bcd_0} = {4'd1, 4'd2, 4'd3};
        @(negedge clk);
        update = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            update = 1'b0;
            if (a_e) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL rst_mid_wait got e=%b exp 1 within 20 cycles", a_e);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({a_e, a_busy, a_done, a_rs, a_rw, a_data} !== 12'h000) begin
            fails++; $display("FAIL rst_mid_outputs got e=%b busy=%b done=%b rs=%b rw=%b data=%h exp all 0", a_e, a_busy, a_done, a_rs, a_rw, a_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_done) nd++;
            if (a_busy) nb++;
        end
        tests++;
        if (nd !== 0 || nb !== 0) begin fails++; $display("FAIL rst_no_resume got done=%0d busy=%0d exp 0 0", nd, nb); end
    endtask

    task automatic test_ignore;
        int nd, nb;
        nd = 0; nb = 0;
        @(negedge clk);
        update = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            update = (i == 3 || i == 10 || i == 20 || i == 30);
            if (a_done) nd++;
            if (a_busy) nb++;
        end
        update = 1'b0;
        tests++;
        if (nd !== 1 || nb !== 40) begin fails++; $display("FAIL ignore_busy got done=%0d busy=%0d exp 1 40", nd, nb); end
    endtask

    task automatic test_back_to_back;
        int nb, nd;
        bit seen;
        seen = 1'b0; nb = 1; nd = 0;
        @(negedge clk);
        update = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            update = 1'b0;
            if (a_done) seen = 1'b1;
        end
        tests++;
        if (!seen || a_busy !== 1'b0) begin
            fails++; $display("FAIL b2b_done got done_seen=%b busy=%b exp 1 0", seen, a_busy);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        tests++;
        if ({a_busy, a_rs, a_data} !== {1'b1, 1'b0, 8'hC0}) begin
            fails++; $display("FAIL b2b_restart got busy=%b rs=%b data=%h exp 1 0 c0", a_busy, a_rs, a_data);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_busy) nb++;
            if (a_done) nd++;
        end
        tests++;
        if (nb !== 40 || nd !== 1) begin fails++; $display("FAIL b2b_second got busy=%0d done=%0d exp 40 1", nb, nd); end
    endtask

    task automatic test_held;
        int t[4];
        int n;
        n = 0;
        @(negedge clk);
        update = 1'b1;
        for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            if (a_done && n < 4) begin t[n] = i; n++; end
        end
        update = 1'b0;
        tests++;
        if (n < 4) begin
            fails++; $display("FAIL held_count got %0d exp 4", n);
        end else begin
            tests++;
            if (t[1] - t[0] !== 41 || t[2] - t[1] !== 41 || t[3] - t[2] !== 41) begin
                fails++; $display("FAIL held_period got %0d %0d %0d exp 41 41 41", t[1]-t[0], t[2]-t[1], t[3]-t[2]);
            end
        end
        repeat (60) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_full;
        test_blank;
        test_noblank;
        test_invalid_latch;
        test_reset_mid_pulse;
        test_ignore;
        test_back_to_back;
        test_held;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
